// File: rtl/uart_reg_ctrl.sv
// ---------------------------------------------------------------------------
// uart_reg_ctrl
//
// Byte-level command sequencer sitting between the UART core and the R-peak
// detector datapath. The host talks a tiny register protocol:
//   command byte = {4'b0000, addr[2:0], rw}
//   rw=1 : the next received byte is written to addr
//   rw=0 : one response byte is returned on TX
//
// Register map
//   0 SR    (R)  {4'b0, perr, ovf, sample_full, peak_empty}
//   1 DINL  (W)  low byte of the next ECG sample
//   2 DINH  (W)  high bits of the sample; writing it pushes {DINH, DINL}
//   3 DOUTL (R)  pops the peak FIFO into the hold register, returns [7:0]
//   4 DOUTM (R)  hold[15:8]
//   5 DOUTH (R)  hold[23:16]
//   6,7          reserved, read as 0x00, writes discarded
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   rx_data_valid, rx_data[7:0]     received byte strobe and value
//   tx_ready                        UART TX can take a byte this cycle
//   tx_data_valid, tx_data[7:0]     response byte strobe and value
//   sample_wr, sample_data          one-cycle push into the sample FIFO
//   sample_full                     sample FIFO full
//   peak_rd                         one-cycle pop of the peak FIFO
//   peak_data, peak_empty           FWFT head of the peak FIFO, empty flag
// ---------------------------------------------------------------------------
module uart_reg_ctrl #(
    parameter int DATA_WIDTH     = 11,
    parameter int CTR_WIDTH      = 22,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_data_valid,
    input  logic [7:0]            rx_data,
    input  logic                  tx_ready,
    output logic                  tx_data_valid,
    output logic [7:0]            tx_data,
    output logic                  sample_wr,
    output logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  sample_full,
    output logic                  peak_rd,
    input  logic [CTR_WIDTH-1:0]  peak_data,
    input  logic                  peak_empty
);

    localparam int HOLD_W = 24;
    localparam int TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] A_SR    = 3'd0;
    localparam logic [2:0] A_DINL  = 3'd1;
    localparam logic [2:0] A_DINH  = 3'd2;
    localparam logic [2:0] A_DOUTL = 3'd3;
    localparam logic [2:0] A_DOUTM = 3'd4;
    localparam logic [2:0] A_DOUTH = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            addr_q, addr_d;
    logic [7:0]            dinl_q, dinl_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [7:0]            resp_q, resp_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic                  sample_wr_q, sample_wr_d;
    logic [DATA_WIDTH-1:0] sample_data_q, sample_data_d;
    logic                  peak_rd_q, peak_rd_d;
    logic                  ovf_q, ovf_d;
    logic                  perr_q, perr_d;

    logic                  ovf_set;
    logic                  perr_set;
    logic                  sr_clr;
    logic                  resp_fire;

    // ---------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= 3'd0;
            dinl_q        <= 8'd0;
            hold_q        <= '0;
            resp_q        <= 8'd0;
            to_cnt_q      <= '0;
            sample_wr_q   <= 1'b0;
            sample_data_q <= '0;
            peak_rd_q     <= 1'b0;
            ovf_q         <= 1'b0;
            perr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            dinl_q        <= dinl_d;
            hold_q        <= hold_d;
            resp_q        <= resp_d;
            to_cnt_q      <= to_cnt_d;
            sample_wr_q   <= sample_wr_d;
            sample_data_q <= sample_data_d;
            peak_rd_q     <= peak_rd_d;
            ovf_q         <= ovf_d;
            perr_q        <= perr_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state and register-update logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        dinl_d        = dinl_q;
        hold_d        = hold_q;
        resp_d        = resp_q;
        to_cnt_d      = to_cnt_q;
        sample_wr_d   = 1'b0;
        sample_data_d = sample_data_q;
        peak_rd_d     = 1'b0;
        ovf_set       = 1'b0;
        perr_set      = 1'b0;
        sr_clr        = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_data_valid) begin
                    if (rx_data[7:4] != 4'd0) begin
                        perr_set = 1'b1;
                    end else begin
                        addr_d = rx_data[3:1];
                        if (rx_data[0]) begin
                            state_d  = WDATA;
                            to_cnt_d = '0;
                        end else begin
                            state_d = RESP;
                            // Response is frozen here so a slow tx_ready
                            // cannot change what the host gets back.
                            case (rx_data[3:1])
                                A_SR: begin
                                    resp_d = {4'd0, perr_q, ovf_q, sample_full, peak_empty};
                                end
                                A_DOUTL: begin
                                    if (!peak_empty) begin
                                        hold_d    = HOLD_W'(peak_data);
                                        peak_rd_d = 1'b1;
                                        resp_d    = peak_data[7:0];
                                    end else begin
                                        resp_d = hold_q[7:0];
                                    end
                                end
                                A_DOUTM: resp_d = hold_q[15:8];
                                A_DOUTH: resp_d = hold_q[23:16];
                                default: resp_d = 8'h00;
                            endcase
                        end
                    end
                end
            end

            WDATA: begin
                if (rx_data_valid) begin
                    state_d = IDLE;
                    case (addr_q)
                        A_DINL: dinl_d = rx_data;
                        A_DINH: begin
                            if (!sample_full) begin
                                sample_wr_d   = 1'b1;
                                // dinl_q is kept so repeated DINH writes reuse it.
                                sample_data_d = DATA_WIDTH'({rx_data, dinl_q});
                            end else begin
                                ovf_set = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else if (to_cnt_q == TO_LAST) begin
                    perr_set = 1'b1;
                    state_d  = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            RESP: begin
                if (rx_data_valid) begin
                    perr_set = 1'b1;
                end
                if (tx_ready) begin
                    state_d = IDLE;
                    if (addr_q == A_SR) begin
                        sr_clr = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Sticky flags: a set in the same cycle as the read-clear wins.
        ovf_d  = ovf_set  | (ovf_q  & ~sr_clr);
        perr_d = perr_set | (perr_q & ~sr_clr);
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    always_comb begin
        resp_fire     = (state_q == RESP) && tx_ready;
        tx_data_valid = resp_fire;
        tx_data       = resp_fire ? resp_q : 8'h00;
        sample_wr     = sample_wr_q;
        sample_data   = sample_data_q;
        peak_rd       = peak_rd_q;
    end

endmodule
